// File: rtl/mix_columns_serial.sv
// AES MixColumns stage, one 32-bit column per clock, with a per-pointer pass counter that bypasses the final round.
// Optional debug status register enabled by defining MIX_COLUMNS_DEBUG_EN.
`timescale 1ns/1ps
module mix_columns_serial (
  input  logic         clk,
  input  logic         reset,
  input  logic [127:0] data_in,
  input  logic         data_in_vld,
  output logic         data_in_rdy,
  input  logic [1:0]   pntr_num_in,
  input  logic         cpu_rd,
  output logic [127:0] data_out,
  output logic         data_out_vld,
  output logic [1:0]   pntr_num_out,
  output logic [31:0]  debug_out
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    COL  = 2'd1,
    BYP  = 2'd2
  } state_e;

  localparam logic [3:0] LAST_PASS = 4'd9;

  state_e       state_q, state_d;
  logic [127:0] blk_q, blk_d;
  logic [1:0]   pntr_q, pntr_d;
  logic [1:0]   col_idx_q, col_idx_d;
  logic [127:0] result_q, result_d;
  logic [3:0]   pass_cnt_q [4];
  logic [3:0]   pass_cnt_d [4];
  logic [127:0] data_out_q, data_out_d;
  logic         data_out_vld_q, data_out_vld_d;
  logic [1:0]   pntr_num_out_q, pntr_num_out_d;

  logic [31:0]  col_in;
  logic [31:0]  col_mixed;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    xtime = {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
  endfunction

  function automatic logic [31:0] mix_column(input logic [31:0] c);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] x0, x1, x2, x3;
    a0 = c[31:24];
    a1 = c[23:16];
    a2 = c[15:8];
    a3 = c[7:0];
    x0 = xtime(a0);
    x1 = xtime(a1);
    x2 = xtime(a2);
    x3 = xtime(a3);
    mix_column[31:24] = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
    mix_column[23:16] = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
    mix_column[15:8]  = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
    mix_column[7:0]   = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
  endfunction

  // Column 0 occupies the most significant word of the state block.
  function automatic logic [31:0] get_col(input logic [127:0] blk, input logic [1:0] idx);
    case (idx)
      2'd0:    get_col = blk[127:96];
      2'd1:    get_col = blk[95:64];
      2'd2:    get_col = blk[63:32];
      default: get_col = blk[31:0];
    endcase
  endfunction

  function automatic logic [127:0] set_col(input logic [127:0] blk, input logic [1:0] idx,
                                           input logic [31:0] c);
    set_col = blk;
    case (idx)
      2'd0:    set_col[127:96] = c;
      2'd1:    set_col[95:64]  = c;
      2'd2:    set_col[63:32]  = c;
      default: set_col[31:0]   = c;
    endcase
  endfunction

  assign col_in    = get_col(blk_q, col_idx_q);
  assign col_mixed = mix_column(col_in);

  assign data_in_rdy  = (state_q == IDLE);
  assign data_out     = data_out_q;
  assign data_out_vld = data_out_vld_q;
  assign pntr_num_out = pntr_num_out_q;

  always_comb begin
    state_d        = state_q;
    blk_d          = blk_q;
    pntr_d         = pntr_q;
    col_idx_d      = col_idx_q;
    result_d       = result_q;
    pass_cnt_d     = pass_cnt_q;
    data_out_d     = data_out_q;
    data_out_vld_d = 1'b0;
    pntr_num_out_d = pntr_num_out_q;

    case (state_q)
      IDLE: begin
        if (data_in_vld) begin
          blk_d     = data_in;
          pntr_d    = pntr_num_in;
          col_idx_d = '0;
          if (pass_cnt_q[pntr_num_in] == LAST_PASS) begin
            pass_cnt_d[pntr_num_in] = '0;
            state_d                 = BYP;
          end else begin
            pass_cnt_d[pntr_num_in] = pass_cnt_q[pntr_num_in] + 4'd1;
            state_d                 = COL;
          end
        end
      end
      COL: begin
        result_d  = set_col(result_q, col_idx_q, col_mixed);
        col_idx_d = col_idx_q + 2'd1;
        // Last column is folded straight into data_out so the pulse lands on the IDLE edge.
        if (col_idx_q == 2'd3) begin
          state_d        = IDLE;
          data_out_d     = result_d;
          data_out_vld_d = 1'b1;
          pntr_num_out_d = pntr_q;
        end
      end
      BYP: begin
        state_d        = IDLE;
        data_out_d     = blk_q;
        data_out_vld_d = 1'b1;
        pntr_num_out_d = pntr_q;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q        <= IDLE;
      blk_q          <= '0;
      pntr_q         <= '0;
      col_idx_q      <= '0;
      result_q       <= '0;
      for (int unsigned i = 0; i < 4; i++) begin
        pass_cnt_q[i] <= '0;
      end
      data_out_q     <= '0;
      data_out_vld_q <= 1'b0;
      pntr_num_out_q <= '0;
    end else begin
      state_q        <= state_d;
      blk_q          <= blk_d;
      pntr_q         <= pntr_d;
      col_idx_q      <= col_idx_d;
      result_q       <= result_d;
      pass_cnt_q     <= pass_cnt_d;
      data_out_q     <= data_out_d;
      data_out_vld_q <= data_out_vld_d;
      pntr_num_out_q <= pntr_num_out_d;
    end
  end

`ifdef MIX_COLUMNS_DEBUG_EN
  logic       overrun_q, overrun_d;
  logic       rd_hit_q, rd_hit_d;
  logic [7:0] vld_cnt_q, vld_cnt_d;

  always_comb begin
    overrun_d = overrun_q | (data_in_vld & ~data_in_rdy);
    rd_hit_d  = rd_hit_q | (cpu_rd & data_out_vld_q);
    vld_cnt_d = vld_cnt_q + {7'd0, data_out_vld_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      overrun_q <= 1'b0;
      rd_hit_q  <= 1'b0;
      vld_cnt_q <= '0;
    end else begin
      overrun_q <= overrun_d;
      rd_hit_q  <= rd_hit_d;
      vld_cnt_q <= vld_cnt_d;
    end
  end

  assign debug_out = {16'd0, vld_cnt_q, 6'd0, rd_hit_q, overrun_q};
`else
  logic unused_cpu_rd;
  assign unused_cpu_rd = cpu_rd;
  assign debug_out     = '0;
`endif

endmodule
